neuro_tx_arbiter: RTL and testbench
===================================

// Module: neuro_tx_arbiter
// PURPOSE
//   Round-robin arbiter sharing the NeuralChip UART transmit byte channel between up to
//   four on-chip report sources (spike events, status, debug taps).
//   Each source offers a 16-bit message. The winner is framed as 3 bytes: header, MSB, LSB.
//   Bytes are streamed to the UART TX byte interface with a valid/ready handshake.
//   Sits between the neuron-core report sources and the UART transmitter inside NeuralChip.
// PARAMETERS
//   NREQ     4   number of requesters, legal 2..4 (ID field is fixed 2 bits)
//   HDR_TAG  4'hA  upper nibble of every header byte
// PORTS
//   clk        in   1        system clock, all logic on rising edge
//   rst_n      in   1        asynchronous active-low reset
//   req_valid  in   NREQ     requester i has a message on req_data
//   req_data   in   16*NREQ  message i occupies bits [16*i+15:16*i]
//   req_ready  out  NREQ     one-hot grant/accept; transfer when valid&ready
//   tx_valid   out  1        tx_data holds a byte for the UART
//   tx_data    out  8        byte to transmit
//   tx_ready   in   1        UART accepts tx_data this cycle
//   busy       out  1        high whenever state != IDLE
//   grant_id   out  2        ID of the packet in flight (last granted when IDLE)
//   pkt_cnt    out  8        completed packets, wraps 255->0
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     state=IDLE; tx_valid=0; tx_data=0; busy=0; grant_id=0; pkt_cnt=0;
//     rr_ptr=0; seq=0; req_ready=0. Async assert, sync-released by an upstream synchroniser.
//   FSM states: IDLE -> HDR -> MSB -> LSB -> IDLE.
//   IDLE:
//     - g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//     - req_ready[g]=1 combinationally, only in IDLE and only when some valid is high.
//       All other bits are 0.
//     - On that edge: latch req_data[g] into msg_q, grant_id<=g,
//       rr_ptr<=(g+1) mod NREQ, state<=HDR.
//     - No valid: stay IDLE; rr_ptr unchanged.
//   HDR/MSB/LSB:
//     - tx_valid=1 (registered, asserted the cycle after the grant edge).
//     - tx_data = {HDR_TAG, seq[1:0], grant_id}, then msg_q[15:8], then msg_q[7:0].
//     - Advance only on an edge with tx_ready=1.
//     - tx_data and tx_valid held stable while tx_ready=0, with no timeout.
//   LSB accepted: state<=IDLE, tx_valid<=0, seq<=seq+1 (mod 4), pkt_cnt<=pkt_cnt+1 (mod 256).
//   Latency: grant edge -> header valid next cycle.
//     tx_ready tied high: 3 consecutive tx_valid cycles, then 1 IDLE cycle.
//     Max throughput is 1 packet / 4 cycles.
//   Boundaries:
//     - req_valid changes outside IDLE are ignored; message already latched.
//     - Requesters must hold valid+data until accepted.
//     - A single requester continuously valid is re-granted every packet;
//       rr_ptr wraps NREQ-1 -> 0.
//     - rst_n asserted mid-packet: packet dropped, seq/pkt_cnt cleared, tx_valid=0 immediately.
//     - tx_ready high while tx_valid=0: no effect.
// TESTING
//   1. Reset, then req_valid=0001, data0=16'h1234, tx_ready=1
//      -> req_ready=0001 one cycle; bytes A0,12,34 on 3 cycles; pkt_cnt=1.
//   2. req_valid=1111 held, distinct data, tx_ready=1
//      -> grant order IDs 0,1,2,3,0; headers A0,A5,AA,AF,A0 (seq wraps); 4 cycles/packet.
//   3. Single packet, tx_ready low 5 cycles during MSB
//      -> tx_data stays 8'h12 and tx_valid=1 for all stalled cycles; no byte lost or repeated.
//   4. Requester 2 changes req_data during its HDR/MSB
//      -> transmitted payload equals the value latched at grant.
//   5. rst_n pulsed low while in MSB
//      -> tx_valid=0, busy=0, pkt_cnt=0 asynchronously; next packet header carries seq=0.
//   6. Run 256 packets -> pkt_cnt wraps to 0; NREQ=2 build grants alternate IDs 0/1.

Source files
------------

// File: rtl/neuro_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// neuro_tx_arbiter_if
//   Groups the requester-side and UART-side handshake signals of the
//   NeuralChip transmit arbiter into one bundle.
//   Signals:
//     req_valid [NREQ]     requester i offers a message
//     req_data  [16*NREQ]  message i in bits [16*i+15:16*i]
//     req_ready [NREQ]     one-hot accept back to the requesters
//     tx_valid             byte available for the UART
//     tx_data   [8]        byte to transmit
//     tx_ready             UART takes tx_data this cycle
//   Modports:
//     master  the arbiter itself
//     slave   the surrounding requesters + UART
// ---------------------------------------------------------------------------
interface neuro_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [16*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_ready;

    modport master (
        input  req_valid,
        input  req_data,
        input  tx_ready,
        output req_ready,
        output tx_valid,
        output tx_data
    );

    modport slave (
        output req_valid,
        output req_data,
        output tx_ready,
        input  req_ready,
        input  tx_valid,
        input  tx_data
    );
endinterface

// File: rtl/neuro_tx_arbiter.sv
// ---------------------------------------------------------------------------
// neuro_tx_arbiter
//   Round-robin arbiter that shares the UART transmit byte channel between
//   up to four report sources. The winning 16-bit message is framed as three
//   bytes: header {HDR_TAG, seq[1:0], id[1:0]}, message MSB, message LSB.
//   Ports:
//     clk       system clock, rising edge
//     rst_n     asynchronous active-low reset
//     bus       handshake bundle (master side): requesters in, UART out
//     busy      high whenever a packet is in flight
//     grant_id  ID of the packet in flight (last granted when idle)
//     pkt_cnt   completed packets, wraps 255 -> 0
// ---------------------------------------------------------------------------
module neuro_tx_arbiter #(
    parameter int         NREQ    = 4,
    parameter logic [3:0] HDR_TAG = 4'hA
) (
    input  logic                clk,
    input  logic                rst_n,
    neuro_tx_arbiter_if.master  bus,
    output logic                busy,
    output logic [1:0]          grant_id,
    output logic [7:0]          pkt_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_MSB  = 2'd2,
        ST_LSB  = 2'd3
    } state_t;

    state_t      state_q,    state_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q,  tx_data_d;
    logic        busy_q,     busy_d;
    logic [1:0]  grant_id_q, grant_id_d;
    logic [7:0]  pkt_cnt_q,  pkt_cnt_d;
    logic [1:0]  rr_ptr_q,   rr_ptr_d;
    logic [1:0]  seq_q,      seq_d;
    logic [15:0] msg_q,      msg_d;

    // Requests padded to 8 bits so a 3-bit rotated index can address them
    // for any legal NREQ.
    logic [7:0]  req_pad_s;
    logic [2:0]  idx_s;
    logic        take_s;
    logic        gnt_found_s;
    logic [1:0]  gnt_id_s;
    logic [1:0]  rr_next_s;
    logic [15:0] msg_sel_s;
    logic [3:0]  gnt_onehot_s;

    // Round-robin search: first valid requester starting at rr_ptr_q.
    always_comb begin
        req_pad_s   = 8'(bus.req_valid);
        idx_s       = 3'd0;
        take_s      = 1'b0;
        gnt_found_s = 1'b0;
        gnt_id_s    = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s       = {1'b0, rr_ptr_q} + 3'(k);
            // rr_ptr_q + k < 2*NREQ, so one conditional subtract is the modulo.
            idx_s       = (idx_s >= 3'(NREQ)) ? (idx_s - 3'(NREQ)) : idx_s;
            take_s      = !gnt_found_s && req_pad_s[idx_s];
            gnt_id_s    = take_s ? idx_s[1:0] : gnt_id_s;
            gnt_found_s = gnt_found_s | take_s;
        end
    end

    // Winner's message, pointer after the winner, and the one-hot accept.
    always_comb begin
        msg_sel_s = 16'd0;
        for (int k = 0; k < NREQ; k++) begin
            msg_sel_s = (gnt_id_s == 2'(k)) ? bus.req_data[16*k +: 16] : msg_sel_s;
        end
        rr_next_s    = (gnt_id_s == 2'(NREQ - 1)) ? 2'd0 : (gnt_id_s + 2'd1);
        gnt_onehot_s = (gnt_found_s && (state_q == ST_IDLE)) ? (4'b0001 << gnt_id_s) : 4'b0000;
    end

    // Next-state logic of the framing FSM and all its registered outputs.
    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        grant_id_d = grant_id_q;
        pkt_cnt_d  = pkt_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        seq_d      = seq_q;
        msg_d      = msg_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_found_s) begin
                    msg_d      = msg_sel_s;
                    grant_id_d = gnt_id_s;
                    rr_ptr_d   = rr_next_s;
                    state_d    = ST_HDR;
                    tx_valid_d = 1'b1;
                    tx_data_d  = {HDR_TAG, seq_q, gnt_id_s};
                    busy_d     = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (bus.tx_ready) begin
                    state_d   = ST_MSB;
                    tx_data_d = msg_q[15:8];
                end else begin
                    state_d   = ST_HDR;
                end
            end
            ST_MSB: begin
                if (bus.tx_ready) begin
                    state_d   = ST_LSB;
                    tx_data_d = msg_q[7:0];
                end else begin
                    state_d   = ST_MSB;
                end
            end
            ST_LSB: begin
                if (bus.tx_ready) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    seq_d      = seq_q + 2'd1;
                    pkt_cnt_d  = pkt_cnt_q + 8'd1;
                end else begin
                    state_d    = ST_LSB;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
            busy_q     <= 1'b0;
            grant_id_q <= 2'd0;
            pkt_cnt_q  <= 8'd0;
            rr_ptr_q   <= 2'd0;
            seq_q      <= 2'd0;
            msg_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
            pkt_cnt_q  <= pkt_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            seq_q      <= seq_d;
            msg_q      <= msg_d;
        end
    end

    assign bus.req_ready = gnt_onehot_s[NREQ-1:0];
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign busy          = busy_q;
    assign grant_id      = grant_id_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_neuro_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_neuro_tx_arbiter
//   Randomised requesters and UART back-pressure. A packet-level reference
//   model picks winners round-robin and pushes the three expected bytes into
//   a queue; an independent monitor pops and compares on every accepted byte.
// ---------------------------------------------------------------------------
module tb_neuro_tx_arbiter;

    localparam int NREQ = 4;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [1:0] grant_id;
    logic [7:0] pkt_cnt;

    neuro_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    neuro_tx_arbiter #(.NREQ(NREQ), .HDR_TAG(4'hA)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id),
        .pkt_cnt  (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state (packet level)
    logic [7:0] exp_q[$];
    int m_busy = 0;
    int m_left = 0;
    int m_seq  = 0;
    int m_pkt  = 0;
    int m_rr   = 0;
    int m_gid  = 0;

    // Requester stimulus state
    bit          has_msg [NREQ];
    logic [15:0] dat     [NREQ];
    logic [NREQ-1:0] hs = '0;
    int p_new   = 0;
    int p_ready = 100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // First valid requester searching from rr, wrapping mod NREQ; -1 if none.
    function automatic int pick(input logic [NREQ-1:0] v, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_busy = 0; m_left = 0; m_seq = 0; m_pkt = 0; m_rr = 0; m_gid = 0;
    endtask

    // Reference model: advances once per clock edge from the bench-driven inputs.
    always @(posedge clk) begin
        if (rst_n) begin
            if (m_busy != 0) begin
                if (bus.tx_ready) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 0;
                        m_seq  = (m_seq + 1) % 4;
                        m_pkt  = (m_pkt + 1) % 256;
                    end
                end
            end else begin
                int g;
                logic [15:0] d;
                g = pick(bus.req_valid, m_rr);
                if (g >= 0) begin
                    d = bus.req_data[16*g +: 16];
                    exp_q.push_back(8'hA0 | 8'((m_seq << 2) | g));
                    exp_q.push_back(d[15:8]);
                    exp_q.push_back(d[7:0]);
                    m_gid  = g;
                    m_rr   = (g + 1) % NREQ;
                    m_busy = 1;
                    m_left = 3;
                end
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle and consumes accepted bytes.
    always @(negedge clk) begin
        int g;
        logic [NREQ-1:0] exp_rdy;
        exp_rdy = '0;
        g = pick(bus.req_valid, m_rr);
        if (m_busy == 0 && g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("tx_valid", 32'(bus.tx_valid), 32'(m_busy));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
        if (bus.tx_valid) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_byte");
            end else begin
                chk("tx_data", 32'(bus.tx_data), 32'(exp_q[0]));
                if (bus.tx_ready) void'(exp_q.pop_front());
            end
        end
        if (rst_n) hs = hs | (bus.req_valid & bus.req_ready);
    end

    // One cycle of requester/UART stimulus, driven just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) has_msg[i] = 1'b0;
            if (!has_msg[i] && ($urandom_range(99, 0) < p_new)) begin
                has_msg[i] = 1'b1;
                dat[i]     = 16'($urandom);
            end
            bus.req_valid[i]          = has_msg[i];
            bus.req_data[16*i +: 16]  = dat[i];
        end
        hs = '0;
        bus.tx_ready = ($urandom_range(99, 0) < p_ready);
    endtask

    task automatic run(input int n, input int pn, input int pr);
        p_new   = pn;
        p_ready = pr;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int guard;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_ready  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            has_msg[i] = 1'b0;
            dat[i]     = 16'd0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single requester 0 with 16'h1234: expect A0, 12, 34
        has_msg[0] = 1'b1;
        dat[0]     = 16'h1234;
        run(8, 0, 100);

        // All requesters continuously valid, UART always ready
        run(40, 100, 100);

        // Random traffic with back-pressure
        run(600, 40, 50);

        // Async reset while the MSB byte is on the bus
        p_new = 100; p_ready = 100;
        guard = 0;
        while (!(m_busy != 0 && m_left == 2) && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) fail_now("reach_msb_timeout");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Saturated traffic long enough to wrap pkt_cnt past 255
        run(1100, 100, 100);

        // More random traffic, then drain
        run(300, 30, 70);
        run(30, 0, 100);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
